// File: rtl/ccu_pkg.sv
// Shared definitions for the layer-sequencing config control unit:
// FSM state encoding and config-word field layout.
package ccu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CFG  = 3'd1,
    ST_LY_CFG  = 3'd2,
    ST_LY_WORK = 3'd3,
    ST_FNH     = 3'd4
  } state_t;

  // Opcode sits in the top byte of every config word.
  localparam int          OPCODE_WIDTH = 8;
  localparam logic [7:0]  OP_END       = 8'hFF;

  // Bit offsets (MSB positions) of the opcode and enable-mask fields.
  function automatic int opcode_msb(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int en_mask_msb(input int data_width);
    return data_width - OPCODE_WIDTH - 1;
  endfunction

endpackage

// File: rtl/FIFO_FWFT.sv
// First-word-fall-through FIFO: the head word is visible on dout whenever
// empty is low; pop retires it. Push into a full FIFO and pop from an empty
// FIFO are both dropped.
module FIFO_FWFT #(
  parameter int DATA_WIDTH      = 128,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int                     DEPTH   = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_W = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]   count;
  logic                       do_push;
  logic                       do_pop;

  // Flags decode the registered count, so a pop on a full FIFO only frees
  // the slot for the host on the following cycle.
  assign full    = (count == DEPTH_W);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; valid contents are tracked solely by
  // the pointers and count, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ccu_layer_seq.sv
// Layer-sequencing config control unit. Buffers host config words in a FWFT
// FIFO; after Start, takes one layer word at a time, broadcasts it to the
// enabled engine channels with per-channel valid/ready, waits for all enabled
// channels to report finish, then advances. An END word closes the network.
module ccu_layer_seq
  import ccu_pkg::*;
#(
  parameter int DATA_WIDTH      = 128,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int NUM_MOD         = 4,
  parameter int LY_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ITF_Dat,
  input  logic                  ITF_DatVld,
  output logic                  ITF_DatRdy,
  input  logic                  Start,
  output logic [DATA_WIDTH-1:0] CfgWord,
  output logic [NUM_MOD-1:0]    CfgVld,
  input  logic [NUM_MOD-1:0]    CfgRdy,
  input  logic [NUM_MOD-1:0]    ModFnh,
  output logic [LY_WIDTH-1:0]   LyIdx,
  output logic                  Busy,
  output logic                  Done
);

  localparam int OP_MSB = opcode_msb(DATA_WIDTH);
  localparam int EN_MSB = en_mask_msb(DATA_WIDTH);

  state_t                  state;
  logic [NUM_MOD-1:0]      en_mask;
  logic [NUM_MOD-1:0]      acc;
  logic [NUM_MOD-1:0]      fin;

  logic [DATA_WIDTH-1:0]   fifo_head;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [OPCODE_WIDTH-1:0] head_op;
  logic [NUM_MOD-1:0]      head_mask;
  logic                    head_is_end;

  logic [NUM_MOD-1:0]      cfg_hs;
  logic [NUM_MOD-1:0]      acc_nxt;
  logic [NUM_MOD-1:0]      fin_nxt;

  assign head_op     = fifo_head[OP_MSB -: OPCODE_WIDTH];
  assign head_mask   = fifo_head[EN_MSB -: NUM_MOD];
  assign head_is_end = (head_op == OP_END);

  // Host may prefetch words in any state, including IDLE.
  assign ITF_DatRdy = ~fifo_full;
  assign fifo_push  = ITF_DatVld & ITF_DatRdy;

  // The head word is retired either when its layer completes or when it is
  // the END marker being consumed.
  assign fifo_pop = ~fifo_empty &
                    ((state == ST_FNH) || ((state == ST_RD_CFG) && head_is_end));

  // CfgVld only ever carries enabled channels, so ready on disabled channels
  // can never form a handshake; finish is masked explicitly.
  assign cfg_hs  = CfgVld & CfgRdy;
  assign acc_nxt = acc | cfg_hs;
  assign fin_nxt = fin | (ModFnh & en_mask);

  FIFO_FWFT #(
    .DATA_WIDTH      (DATA_WIDTH),
    .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) U_FIFO_CFG (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (ITF_Dat),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Layer sequencing FSM with registered outputs and accept/finish masks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      CfgWord <= '0;
      CfgVld  <= '0;
      LyIdx   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      en_mask <= '0;
      acc     <= '0;
      fin     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            Busy  <= 1'b1;
            LyIdx <= '0;
            state <= ST_RD_CFG;
          end
        end

        ST_RD_CFG: begin
          if (!fifo_empty) begin
            if (head_is_end) begin
              Done  <= 1'b1;
              Busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              CfgWord <= fifo_head;
              en_mask <= head_mask;
              if (head_mask == '0) begin
                state <= ST_FNH;
              end else begin
                CfgVld <= head_mask;
                state  <= ST_LY_CFG;
              end
            end
          end
        end

        ST_LY_CFG: begin
          // Early finishes, even in the handshake cycle itself, are kept.
          CfgVld <= CfgVld & ~cfg_hs;
          acc    <= acc_nxt;
          fin    <= fin_nxt;
          if ((acc_nxt & en_mask) == en_mask) state <= ST_LY_WORK;
        end

        ST_LY_WORK: begin
          fin <= fin_nxt;
          if (fin == en_mask) state <= ST_FNH;
        end

        ST_FNH: begin
          LyIdx <= LyIdx + 1'b1;
          acc   <= '0;
          fin   <= '0;
          state <= ST_RD_CFG;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_layer_seq.sv
// Directed bench for ccu_layer_seq: table-driven single-layer run plus
// hand-written sequences for stalls, early finish, empty masks, FIFO full
// and asynchronous reset.
module tb_ccu_layer_seq;

  localparam int DW = 128;
  localparam int NM = 4;
  localparam int LW = 8;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] ITF_Dat;
  logic          ITF_DatVld;
  logic          ITF_DatRdy;
  logic          Start;
  logic [DW-1:0] CfgWord;
  logic [NM-1:0] CfgVld;
  logic [NM-1:0] CfgRdy;
  logic [NM-1:0] ModFnh;
  logic [LW-1:0] LyIdx;
  logic          Busy;
  logic          Done;

  int n_tests = 0;
  int n_fail  = 0;

  ccu_layer_seq #(
    .DATA_WIDTH      (DW),
    .FIFO_ADDR_WIDTH (4),
    .NUM_MOD         (NM),
    .LY_WIDTH        (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ITF_Dat    (ITF_Dat),
    .ITF_DatVld (ITF_DatVld),
    .ITF_DatRdy (ITF_DatRdy),
    .Start      (Start),
    .CfgWord    (CfgWord),
    .CfgVld     (CfgVld),
    .CfgRdy     (CfgRdy),
    .ModFnh     (ModFnh),
    .LyIdx      (LyIdx),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [NM-1:0] rdy;
    logic [NM-1:0] fnh;
    logic [NM-1:0] e_vld;
    logic          e_busy;
    logic          e_done;
    logic [LW-1:0] e_ly;
  } vec_t;

  vec_t tv[10];

  function automatic logic [DW-1:0] mkw(input logic [7:0] op, input logic [3:0] m,
                                        input logic [31:0] p);
    return {op, m, 84'd0, p};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ITF_DatVld = 1'b0;
    ITF_Dat    = '0;
    Start      = 1'b0;
    CfgRdy     = '0;
    ModFnh     = '0;
    rst_n      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #6 rst_n = 1'b1;
    step();
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    ITF_Dat    = w;
    ITF_DatVld = 1'b1;
    check("push_rdy", ITF_DatRdy, 1'b1);
    step();
    ITF_DatVld = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      step();
      if (Done) break;
    end
    check(name, (k < budget), 1'b1);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rec [16];
    logic [DW-1:0] last;
    int            n_rec;
    logic          late_pushed;
    logic          accepted;
    int            cyc;

    // ---------------- Reset state ----------------
    rst_n      = 1'b0;
    ITF_DatVld = 1'b0;
    ITF_Dat    = '0;
    Start      = 1'b0;
    CfgRdy     = '0;
    ModFnh     = '0;
    #3;
    check("rst_cfgvld", CfgVld, '0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_lyidx", LyIdx, '0);
    check("rst_cfgword", CfgWord, '0);
    #20 rst_n = 1'b1;
    step();

    // ---------------- Test 1: table-driven single layer ----------------
    // Layer EnMask=0011, then END; all ready; finish ch0 then ch1.
    tv[0] = '{1'b1, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 8'd0};
    tv[1] = '{1'b0, 4'hF, 4'h0, 4'b0011, 1'b1, 1'b0, 8'd0};
    tv[2] = '{1'b0, 4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 8'd0};
    tv[3] = '{1'b0, 4'h0, 4'h1, 4'b0000, 1'b1, 1'b0, 8'd0};
    tv[4] = '{1'b0, 4'h0, 4'h0, 4'b0000, 1'b1, 1'b0, 8'd0};
    tv[5] = '{1'b0, 4'h0, 4'h2, 4'b0000, 1'b1, 1'b0, 8'd0};
    tv[6] = '{1'b0, 4'h0, 4'h0, 4'b0000, 1'b1, 1'b0, 8'd0};
    tv[7] = '{1'b0, 4'h0, 4'h0, 4'b0000, 1'b1, 1'b0, 8'd1};
    tv[8] = '{1'b0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b1, 8'd1};
    tv[9] = '{1'b0, 4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 8'd1};

    push_word(mkw(8'h01, 4'b0011, 32'd1));
    push_word(mkw(8'hFF, 4'b0000, 32'd0));
    for (int i = 0; i < 10; i++) begin
      Start  = tv[i].start;
      CfgRdy = tv[i].rdy;
      ModFnh = tv[i].fnh;
      step();
      check($sformatf("t1_vld[%0d]", i), CfgVld, tv[i].e_vld);
      check($sformatf("t1_busy[%0d]", i), Busy, tv[i].e_busy);
      check($sformatf("t1_done[%0d]", i), Done, tv[i].e_done);
      check($sformatf("t1_ly[%0d]", i), LyIdx, tv[i].e_ly);
      if (i == 1) check("t1_cfgword", CfgWord, mkw(8'h01, 4'b0011, 32'd1));
    end
    Start = 1'b0; CfgRdy = '0; ModFnh = '0;

    // ---------------- Test 2: ch1 ready held low ----------------
    do_reset();
    push_word(mkw(8'h01, 4'b0011, 32'd2));
    push_word(mkw(8'hFF, 4'b0000, 32'd0));
    CfgRdy = 4'b0001;
    pulse_start();
    step();
    check("t2_vld_both", CfgVld, 4'b0011);
    step();
    check("t2_vld_partial", CfgVld, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      ModFnh = (i == 3) ? 4'b0011 : 4'b0000;
      step();
      check($sformatf("t2_hold_vld[%0d]", i), CfgVld, 4'b0010);
      check($sformatf("t2_hold_ly[%0d]", i), LyIdx, 8'd0);
    end
    ModFnh = '0;
    CfgRdy = 4'b0011;
    step();
    check("t2_vld_clear", CfgVld, 4'b0000);
    CfgRdy = '0;
    step();
    check("t2_ly_before_fnh", LyIdx, 8'd0);
    step();
    check("t2_ly_after_fnh", LyIdx, 8'd1);
    step();
    check("t2_done", Done, 1'b1);

    // ---------------- Test 3: finish in handshake cycle ----------------
    do_reset();
    push_word(mkw(8'h01, 4'b0100, 32'd3));
    push_word(mkw(8'hFF, 4'b0000, 32'd0));
    pulse_start();
    step();
    check("t3_vld", CfgVld, 4'b0100);
    CfgRdy = 4'b0100;
    ModFnh = 4'b0100;
    step();
    CfgRdy = '0;
    ModFnh = '0;
    check("t3_vld_clear", CfgVld, 4'b0000);
    step();
    step();
    check("t3_ly", LyIdx, 8'd1);
    step();
    check("t3_done", Done, 1'b1);

    // ---------------- Test 4: empty enable mask ----------------
    do_reset();
    push_word(mkw(8'h01, 4'b0000, 32'd40));
    push_word(mkw(8'h01, 4'b1000, 32'd41));
    push_word(mkw(8'hFF, 4'b0000, 32'd0));
    pulse_start();
    step();
    check("t4_vld_mask0", CfgVld, 4'b0000);
    check("t4_word0", CfgWord, mkw(8'h01, 4'b0000, 32'd40));
    step();
    check("t4_vld_fnh", CfgVld, 4'b0000);
    check("t4_ly1", LyIdx, 8'd1);
    step();
    check("t4_vld_next", CfgVld, 4'b1000);
    check("t4_word1", CfgWord, mkw(8'h01, 4'b1000, 32'd41));
    CfgRdy = 4'b1111;
    ModFnh = 4'b1000;
    step();
    CfgRdy = '0;
    ModFnh = '0;
    wait_done("t4_done_timeout", 10);
    check("t4_ly2", LyIdx, 8'd2);

    // ---------------- Test 5: FIFO full and order ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ITF_Dat    = mkw(8'h01, 4'b0000, 32'(100 + i));
      ITF_DatVld = 1'b1;
      check($sformatf("t5_fill_rdy[%0d]", i), ITF_DatRdy, 1'b1);
      step();
    end
    ITF_Dat = mkw(8'hFF, 4'b0000, 32'd0);
    check("t5_full_rdy", ITF_DatRdy, 1'b0);
    step();
    check("t5_full_hold", ITF_DatRdy, 1'b0);
    n_rec       = 0;
    last        = CfgWord;
    late_pushed = 1'b0;
    Start       = 1'b1;
    for (cyc = 0; cyc < 80; cyc++) begin
      accepted = ITF_DatVld & ITF_DatRdy;
      step();
      Start = 1'b0;
      if (accepted) begin
        ITF_DatVld  = 1'b0;
        late_pushed = 1'b1;
      end
      if (CfgWord !== last) begin
        if (n_rec < 16) rec[n_rec] = CfgWord;
        n_rec++;
        last = CfgWord;
      end
      if (Done) break;
    end
    ITF_DatVld = 1'b0;
    check("t5_done_timeout", (cyc < 80), 1'b1);
    check("t5_late_push", late_pushed, 1'b1);
    check("t5_n_words", n_rec, 16);
    for (int i = 0; i < 16; i++) begin
      if (i < n_rec) check($sformatf("t5_order[%0d]", i), rec[i], mkw(8'h01, 4'b0000, 32'(100 + i)));
    end
    check("t5_ly", LyIdx, 8'd16);

    // ---------------- Test 6: empty start, async reset mid-layer ----------------
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) step();
    check("t6_wait_busy", Busy, 1'b1);
    check("t6_wait_vld", CfgVld, 4'b0000);
    push_word(mkw(8'h01, 4'b0000, 32'd50));
    push_word(mkw(8'h01, 4'b0001, 32'd51));
    step();
    check("t6_ly1", LyIdx, 8'd1);
    step();
    check("t6_vld", CfgVld, 4'b0001);
    CfgRdy = 4'b0001;
    step();
    CfgRdy = '0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_vld", CfgVld, 4'b0000);
    check("t6_rst_busy", Busy, 1'b0);
    check("t6_rst_done", Done, 1'b0);
    check("t6_rst_ly", LyIdx, 8'd0);
    check("t6_rst_word", CfgWord, '0);
    #1 rst_n = 1'b1;
    step();
    push_word(mkw(8'h01, 4'b0001, 32'd61));
    push_word(mkw(8'hFF, 4'b0000, 32'd0));
    pulse_start();
    step();
    check("t6_new_vld", CfgVld, 4'b0001);
    check("t6_new_word", CfgWord, mkw(8'h01, 4'b0001, 32'd61));
    CfgRdy = 4'b0001;
    ModFnh = 4'b0001;
    step();
    CfgRdy = '0;
    ModFnh = '0;
    wait_done("t6_done_timeout", 10);
    check("t6_new_ly", LyIdx, 8'd1);
    check("t6_new_busy", Busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
